md_sequencer: RTL and testbench
===============================

# md_sequencer

Multi-cycle multiply/divide sequencer for the RV32M extension in the 5-stage pipeline. It accepts one M-type operation from the Execute stage and runs it over XLEN iterations on an iterative shift-add / restoring-divide core. While the operation is in flight it stalls the pipeline, then returns a registered result with a one-cycle done pulse. The ALU Decoder and single-cycle ALU handle base-ISA ops; this block owns every instruction with opcode OP and funct7 = 0000001.

## Interface
Parameters:
- XLEN, 32, operand/result width; also the iteration count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request from Execute; accepted only in IDLE.
- funct3  in  3  M-op select, sampled on accept.
- src_a  in  XLEN  rs1 operand, sampled on accept.
- src_b  in  XLEN  rs2 operand, sampled on accept.
- flush  in  1  pipeline flush; aborts any operation.
- stall  out  1  combinational pipeline stall request.
- busy  out  1  registered; high in RUN and DONE.
- done  out  1  registered; one-cycle pulse when result is valid.
- result  out  XLEN  registered result; held until the next accept.

## Operation
- funct3 map:
  - 000 MUL: low word.
  - 001 MULH: signed×signed, high word.
  - 010 MULHSU: signed×unsigned, high word.
  - 011 MULHU: unsigned, high word.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- States:
  - IDLE: no operation in flight.
  - RUN: XLEN iterations in progress.
  - DONE: result published; lasts one cycle.
- Accept:
  - A request is accepted when the state is IDLE, start=1 and flush=0.
  - On accept, operand magnitudes, sign-fix flags and the op are latched; the counter loads XLEN-1.
- RUN:
  - Each cycle performs one iteration and decrements the counter.
  - The iteration with counter=0 moves the FSM to DONE.
- Iteration arithmetic:
  - Multiply: 2×XLEN-bit product register, add-then-shift-right.
  - Divide: restoring; the XLEN+1-bit partial remainder is shifted left and the divisor subtracted; a quotient bit is set if the difference is ≥0.
- DONE:
  - Apply the sign fix, write result, pulse done, then return to IDLE.
  - Product sign = sign_a XOR sign_b (MULH/MULHSU).
  - Quotient sign = sign_a XOR sign_b.
  - Remainder sign = sign_a.
- Special cases, detected on accept; these skip RUN and go directly to DONE:
  - Divide by zero: quotient = all ones; remainder = src_a.
  - Signed overflow (src_a = -2^(XLEN-1), src_b = -1, DIV/REM): quotient = src_a; remainder = 0.
- Flush or rst in any state: next state IDLE, no done pulse, result unchanged (rst clears it).
- start in RUN or DONE is ignored; the pipeline is stalled and holds the request.
- stall = (IDLE & start & ~flush) | RUN. It is low in DONE so Execute advances while done=1. It is forced low while rst=1.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0, stall 0.
- Normal latency: with accept in cycle 0, RUN covers cycles 1..XLEN and done=1 in cycle XLEN+1. Back-to-back accept is possible in cycle XLEN+2 at the earliest.
- Special-case latency: done=1 in cycle 1.
- result changes only on the DONE cycle edge and stays stable afterwards.
- flush in the same cycle as start: flush wins; the request is not accepted.
- flush in the same cycle as done: done is still 1 (already registered); the next state is IDLE.

## Configuration
- MD_DIV_EN defined: full RV32M; all eight funct3 codes supported.
- MD_DIV_EN undefined:
  - The divide datapath and its special-case logic are not compiled.
  - funct3[2]=1 requests take the special-case path: done in cycle 1, result = 0.
  - Multiply behaviour and timing are unchanged.

## Structure
- Package md_pkg holds:
  - the md_op_e enum, matching the funct3 codes;
  - the md_state_e enum (IDLE, RUN, DONE);
  - the XLEN default constant;
  - the special-case constants (all-ones quotient, signed-minimum value).
- Sub-module md_iter_core: the product/remainder registers and one-iteration add/subtract-shift logic, with step/load inputs and raw hi/lo outputs.
- The top level keeps the FSM, counter, special-case detection, sign fix and output registers.

## Test plan
- MUL 7 × -3, start in cycle 0: stall high cycles 0..32, done=1 in cycle 33, result = 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF: result = 0xFFFFFFFE. MULH 0x80000000 × 0x80000000: result = 0x40000000.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0: done in cycle 1, result 0xFFFFFFFF. REM 0x80000000 / -1: done in cycle 1, result 0.
- flush in cycle 10 of a RUN: IDLE next cycle, no done, busy=0, old result retained. A new start then completes normally.
- rst in mid-RUN: all outputs 0 on the next cycle. With MD_DIV_EN undefined, DIVU 9/3 gives done in cycle 1, result 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package md_pkg;

  localparam int MD_XLEN = 32;

  // Architectural results for the divide corner cases.
  localparam logic [MD_XLEN-1:0] MD_ALL_ONES = '1;
  localparam logic [MD_XLEN-1:0] MD_SMIN     = {1'b1, {(MD_XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative shift-add multiply / restoring divide datapath on unsigned magnitudes.
// Divide path is only built when MD_DIV_EN is defined.
module md_iter_core
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
`ifdef MD_DIV_EN
  input  logic            is_div,
`endif
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN:0]   sum;
`ifdef MD_DIV_EN
  logic            div_q;
  logic [XLEN:0]   shifted, diff;
`endif

  // hi/lo present the register contents after one more iteration, so the
  // top level can publish the result on the same edge as the final step.
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    hi  = sum[XLEN:1];
    lo  = {sum[0], lo_q[XLEN-1:1]};
`ifdef MD_DIV_EN
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (div_q) begin
      if (!diff[XLEN]) begin
        hi = diff[XLEN-1:0];
        lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi = shifted[XLEN-1:0];
        lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
`ifdef MD_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= op_a;
      b_q   <= op_b;
`ifdef MD_DIV_EN
      div_q <= is_div;
`endif
    end else if (step) begin
      hi_q  <= hi;
      lo_q  <= lo;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// RV32M multi-cycle sequencer: FSM, sign handling, special cases and output registers.
// Define MD_DIV_EN to include DIV/DIVU/REM/REMU; otherwise divide ops return 0 in one cycle.
module md_sequencer
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state, state_nxt;
  md_op_e          op, op_in;
  logic [CW-1:0]   count;
  logic            neg, neg_in, sa, sb;
  logic            accept, special, core_load, core_step;
  logic [XLEN-1:0] mag_a, mag_b, special_val, fix_val, core_hi, core_lo;
  logic [2*XLEN-1:0] prod;

  assign op_in  = md_op_e'(funct3);
  assign accept = (state == IDLE) && start && !flush;
  assign stall  = !rst && (accept || (state == RUN));

  // The core works on magnitudes; neg records whether the final value is negated.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op_in)
      OP_MULH:   begin sa = src_a[XLEN-1]; sb = src_b[XLEN-1]; end
      OP_MULHSU: sa = src_a[XLEN-1];
`ifdef MD_DIV_EN
      OP_DIV, OP_REM: begin sa = src_a[XLEN-1]; sb = src_b[XLEN-1]; end
`endif
      default: ;
    endcase
    mag_a  = sa ? -src_a : src_a;
    mag_b  = sb ? -src_b : src_b;
    neg_in = (op_in == OP_REM) ? sa : (sa ^ sb);
  end

  always_comb begin
    special     = 1'b0;
    special_val = '0;
`ifdef MD_DIV_EN
    if (funct3[2]) begin
      if (src_b == '0) begin
        special     = 1'b1;
        special_val = funct3[1] ? src_a : XLEN'(MD_ALL_ONES);
      end else if (!funct3[0] && src_a == XLEN'(MD_SMIN) && src_b == XLEN'(MD_ALL_ONES)) begin
        special     = 1'b1;
        special_val = funct3[1] ? '0 : src_a;
      end
    end
`else
    special = funct3[2];
`endif
  end

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = special ? DONE : RUN;
        core_load = !special;
      end
      RUN: begin
        core_step = 1'b1;
        if (count == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Evaluated on the final RUN cycle, using the core's post-iteration values.
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg) prod = -prod;
    fix_val = prod[2*XLEN-1:XLEN];
    case (op)
      OP_MUL: fix_val = prod[XLEN-1:0];
`ifdef MD_DIV_EN
      OP_DIV, OP_DIVU: fix_val = neg ? -core_lo : core_lo;
      OP_REM, OP_REMU: fix_val = neg ? -core_hi : core_hi;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_MUL;
      neg    <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      if (accept) begin
        op    <= op_in;
        neg   <= neg_in;
        count <= CW'(XLEN - 1);
      end else if (state == RUN) begin
        count <= count - 1'b1;
      end
      if (state_nxt == DONE)
        result <= (state == IDLE) ? special_val : fix_val;
    end
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (core_load),
    .step  (core_step),
`ifdef MD_DIV_EN
    .is_div(funct3[2]),
`endif
    .op_a  (mag_a),
    .op_b  (mag_b),
    .hi    (core_hi),
    .lo    (core_lo)
  );

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer; expectations adapt to MD_DIV_EN.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB;
  logic        stall, busy, done;
  logic [31:0] result;

  int numChecks = 0;
  int numPass   = 0;

  always #5 clk = ~clk;

  md_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .funct3(funct3),
    .src_a (srcA),
    .src_b (srcB),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual === expected) numPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Issues one op in cycle 0 and checks the stall profile, done cycle and result.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input int expCycle, input logic [31:0] expResult);
    int cyc = 0;
    int doneCycle = -1;
    bit stallBad = 1'b0;
    logic [31:0] resAtDone = '0;
    start = 1'b1; funct3 = f3; srcA = a; srcB = b;
    while (doneCycle < 0 && cyc <= 40) begin
      @(negedge clk);
      if (stall !== (cyc < expCycle)) stallBad = 1'b1;
      if (done === 1'b1) begin
        doneCycle = cyc;
        resAtDone = result;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    checkOutput({tag, "_stall"}, 64'(stallBad), 64'd0);
    checkOutput({tag, "_cycle"}, 64'(doneCycle), 64'(expCycle));
    checkOutput({tag, "_result"}, 64'(resAtDone), 64'(expResult));
    @(negedge clk);
    checkOutput({tag, "_after"}, {30'd0, done, busy, result}, {32'd0, expResult});
    @(posedge clk); #1;
  endtask

  initial begin
    bit sawDone;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset", {29'd0, busy, done, stall, result}, 64'd0);
    @(posedge clk); #1;

    applyStimulus("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB);
    applyStimulus("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
    applyStimulus("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        33, 32'hFFFFFFFF);
    applyStimulus("mulh",   3'b001, 32'h80000000, 32'h80000000, 33, 32'h40000000);

    // Flush in cycle 10 of a RUN: previous result must survive.
    start = 1'b1; funct3 = 3'b000; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", 64'(stall), 64'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle", {30'd0, busy, done, result}, {32'd0, 32'h40000000});
    sawDone = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("flush_nodone", 64'(sawDone), 64'd0);
    @(posedge clk); #1;
    applyStimulus("mul_after_flush", 3'b000, 32'd6, 32'd7, 33, 32'd42);

    // Flush wins over a same-cycle start.
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; srcA = 32'd2; srcB = 32'd2;
    @(negedge clk);
    checkOutput("flush_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_start_idle", {30'd0, busy, done, result}, {32'd0, 32'd42});
    @(posedge clk); #1;

`ifdef MD_DIV_EN
    applyStimulus("div",      3'b100, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD);
    applyStimulus("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF);
    applyStimulus("divu",     3'b101, 32'd100,      32'd7,        33, 32'd14);
    applyStimulus("remu",     3'b111, 32'd100,      32'd7,        33, 32'd2);
    applyStimulus("div_zero", 3'b100, 32'd5,        32'd0,        1,  32'hFFFFFFFF);
    applyStimulus("remu_zero",3'b111, 32'd9,        32'd0,        1,  32'd9);
    applyStimulus("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 1,  32'd0);
    applyStimulus("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000);
`else
    applyStimulus("divu_off", 3'b101, 32'd9,        32'd3,        1,  32'd0);
    applyStimulus("rem_off",  3'b110, 32'hFFFFFFF9, 32'd2,        1,  32'd0);
    applyStimulus("div_off",  3'b100, 32'd5,        32'd0,        1,  32'd0);
`endif
    applyStimulus("mul_last", 3'b000, 32'd1000, 32'd1000, 33, 32'd1000000);

    // Reset in mid-RUN clears every output.
    start = 1'b1; funct3 = 3'b011; srcA = 32'd11; srcB = 32'd13;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_outputs", {29'd0, busy, done, stall, result}, 64'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
